// File: rtl/alu_cmd_issuer_pkg.sv
// Shared types for the ALU command issuer, the combinational ALU and the bench.
// A command is {oc, a, b}; the opcode enum fixes the ALU operation encoding.
package alu_cmd_issuer_pkg;
    localparam int OC_W   = 3;
    localparam int DATA_W = 4;

    typedef enum logic [OC_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NOTA = 3'd5,
        OP_SHL  = 3'd6,
        OP_SHR  = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [OC_W-1:0]   oc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command (producer -> issuer) and result (issuer -> consumer) handshake channels.
// slave is the issuer's view, master is the producer/consumer view.
interface alu_cmd_issuer_if;
    import alu_cmd_issuer_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OC_W-1:0]   in_oc;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [OC_W-1:0]   res_oc;

    modport slave (
        input  in_valid, in_oc, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data, res_oc
    );

    modport master (
        output in_valid, in_oc, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data, res_oc
    );
endinterface

// File: rtl/alu.sv
// Combinational 4-bit ALU driven by the issuer's operand lines.
module alu
    import alu_cmd_issuer_pkg::*;
(
    input  logic [OC_W-1:0]   oc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] out
);
    always_comb begin
        out = '0;
        case (alu_op_e'(oc))
            OP_ADD:  out = a + b;
            OP_SUB:  out = a - b;
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            OP_XOR:  out = a ^ b;
            OP_NOTA: out = ~a;
            OP_SHL:  out = a << 1;
            OP_SHR:  out = a >> 1;
            default: out = '0;
        endcase
    end
endmodule

// File: rtl/alu_cmd_issuer_cmd_fifo.sv
// Command FIFO: power-of-two depth, wrapping pointers, occupancy count, sync flush.
// Push is refused when full even if a pop happens in the same cycle.
module alu_cmd_issuer_cmd_fifo
    import alu_cmd_issuer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  alu_cmd_t      wr_data,
    input  logic          pop,
    output alu_cmd_t      rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    alu_cmd_t      r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_push  = push && !full && !clear;
    assign w_pop   = pop && !empty && !clear;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/alu_cmd_issuer.sv
// FIFO -> issue register (drives ALU operands) -> result register with backpressure.
// Operand lines hold the last issued command so alu_out is stable when captured.
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    alu_cmd_issuer_if.slave   bus,
    output logic [OC_W-1:0]   alu_oc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    output logic [CW-1:0]     count
);
    alu_cmd_t          w_in_cmd;
    alu_cmd_t          w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_res_adv;
    logic              w_iss_adv;

    alu_cmd_t          r_iss_cmd;
    logic              r_iss_v;
    logic              r_res_v;
    logic [DATA_W-1:0] r_res_data;
    logic [OC_W-1:0]   r_res_oc;

    assign w_in_cmd = '{oc: bus.in_oc, a: bus.in_a, b: bus.in_b};

    alu_cmd_issuer_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .push    (bus.in_valid),
        .wr_data (w_in_cmd),
        .pop     (w_iss_adv),
        .rd_data (w_head),
        .count   (count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign w_res_adv = r_iss_v && (!r_res_v || bus.res_ready);
    assign w_iss_adv = !w_empty && (!r_iss_v || w_res_adv);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_cmd  <= '0;
            r_iss_v    <= 1'b0;
            r_res_v    <= 1'b0;
            r_res_data <= '0;
            r_res_oc   <= '0;
        end else if (clear) begin
            // Flush valids only; operand and result data hold their values.
            r_iss_v <= 1'b0;
            r_res_v <= 1'b0;
        end else begin
            if (w_iss_adv) begin
                r_iss_cmd <= w_head;
                r_iss_v   <= 1'b1;
            end else if (w_res_adv) begin
                r_iss_v <= 1'b0;
            end
            if (w_res_adv) begin
                r_res_data <= alu_out;
                r_res_oc   <= r_iss_cmd.oc;
                r_res_v    <= 1'b1;
            end else if (bus.res_ready) begin
                r_res_v <= 1'b0;
            end
        end
    end

    assign alu_oc        = r_iss_cmd.oc;
    assign alu_a         = r_iss_cmd.a;
    assign alu_b         = r_iss_cmd.b;
    assign bus.in_ready  = !w_full;
    assign bus.res_valid = r_res_v;
    assign bus.res_data  = r_res_data;
    assign bus.res_oc    = r_res_oc;
endmodule
